// File: rtl/uart_cmd_link.sv
// Two-byte UART command receiver plus one-byte response transmitter, full duplex.
// Latency: cmd_rdy rises 1 clk after the 2nd stop-bit sample; TX start bit begins 1 clk after send_resp.
// Backpressure: none; bytes arriving while cmd_rdy is high are dropped, and send_resp is ignored mid-frame.
module uart_cmd_link #(
  parameter int BAUD_DIV = 2604
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RX,
  output logic        TX,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic [7:0]  resp,
  input  logic        send_resp,
  output logic        resp_sent
);

  localparam logic [11:0] FULL = 12'(BAUD_DIV);
  localparam logic [11:0] HALF = 12'(BAUD_DIV / 2);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic       {TX_IDLE, TX_XMIT} tx_state_t;

  // receive side
  logic        rx_meta, rx_sync, rx_prev, rx_fall;
  rx_state_t   rx_state, rx_state_nxt;
  logic [11:0] rx_cnt, rx_cnt_nxt;
  logic [2:0]  rx_bit, rx_bit_nxt;
  logic [7:0]  rx_shift, rx_shift_nxt;
  logic        byte_acc;
  logic        byte_idx;
  logic        rdy_pend;
  logic [15:0] idle_cnt;

  // transmit side
  tx_state_t   tx_state, tx_state_nxt;
  logic [11:0] tx_cnt, tx_cnt_nxt;
  logic [3:0]  tx_bit, tx_bit_nxt;
  logic [9:0]  tx_shift, tx_shift_nxt;
  logic        resp_sent_nxt;

  // Bring RX into the clock domain; preset high so reset never looks like a start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= RX;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  assign rx_fall = rx_prev & ~rx_sync;

  // Receiver state register; counter period is the loaded value (expiry at count 1).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
    end else begin
      rx_state <= rx_state_nxt;
      rx_cnt   <= rx_cnt_nxt;
      rx_bit   <= rx_bit_nxt;
      rx_shift <= rx_shift_nxt;
    end
  end

  // Receiver next-state: half-bit to start centre, then full bits sampled mid-bit.
  always_comb begin
    rx_state_nxt = rx_state;
    rx_cnt_nxt   = rx_cnt;
    rx_bit_nxt   = rx_bit;
    rx_shift_nxt = rx_shift;
    byte_acc     = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        if (rx_fall) begin
          rx_state_nxt = RX_START;
          rx_cnt_nxt   = HALF;
        end
      end
      RX_START: begin
        if (rx_cnt == 12'd1) begin
          if (!rx_sync) begin
            rx_state_nxt = RX_DATA;
            rx_cnt_nxt   = FULL;
            rx_bit_nxt   = 3'd0;
          end else begin
            rx_state_nxt = RX_IDLE;
            rx_cnt_nxt   = '0;
          end
        end else begin
          rx_cnt_nxt = rx_cnt - 12'd1;
        end
      end
      RX_DATA: begin
        if (rx_cnt == 12'd1) begin
          rx_shift_nxt = {rx_sync, rx_shift[7:1]};
          rx_cnt_nxt   = FULL;
          if (rx_bit == 3'd7) rx_state_nxt = RX_STOP;
          else                rx_bit_nxt   = rx_bit + 3'd1;
        end else begin
          rx_cnt_nxt = rx_cnt - 12'd1;
        end
      end
      RX_STOP: begin
        if (rx_cnt == 12'd1) begin
          byte_acc     = rx_sync;
          rx_state_nxt = RX_IDLE;
          rx_cnt_nxt   = '0;
        end else begin
          rx_cnt_nxt = rx_cnt - 12'd1;
        end
      end
      default: rx_state_nxt = RX_IDLE;
    endcase
  end

  // Command assembly, ready flag, and resync of a stranded first byte after 65536 idle clocks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd      <= '0;
      byte_idx <= 1'b0;
      rdy_pend <= 1'b0;
      cmd_rdy  <= 1'b0;
      idle_cnt <= '0;
    end else begin
      rdy_pend <= 1'b0;
      if (byte_acc && !cmd_rdy && !rdy_pend) begin
        if (!byte_idx) begin
          cmd[15:8] <= rx_shift;
          byte_idx  <= 1'b1;
        end else begin
          cmd[7:0]  <= rx_shift;
          byte_idx  <= 1'b0;
          rdy_pend  <= 1'b1;
        end
      end else if (byte_idx && rx_state == RX_IDLE && idle_cnt == 16'hFFFF) begin
        byte_idx <= 1'b0;
      end

      if (byte_idx && rx_state == RX_IDLE) idle_cnt <= idle_cnt + 16'd1;
      else                                 idle_cnt <= '0;

      if (clr_cmd_rdy)   cmd_rdy <= 1'b0;
      else if (rdy_pend) cmd_rdy <= 1'b1;
    end
  end

  // Transmitter state register; shifter fills with ones so idle TX is its LSB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state  <= TX_IDLE;
      tx_cnt    <= '0;
      tx_bit    <= '0;
      tx_shift  <= '1;
      resp_sent <= 1'b0;
    end else begin
      tx_state  <= tx_state_nxt;
      tx_cnt    <= tx_cnt_nxt;
      tx_bit    <= tx_bit_nxt;
      tx_shift  <= tx_shift_nxt;
      resp_sent <= resp_sent_nxt;
    end
  end

  // Transmitter next-state: load frame on send_resp, shift each bit period, flag end of stop bit.
  always_comb begin
    tx_state_nxt  = tx_state;
    tx_cnt_nxt    = tx_cnt;
    tx_bit_nxt    = tx_bit;
    tx_shift_nxt  = tx_shift;
    resp_sent_nxt = 1'b0;
    case (tx_state)
      TX_IDLE: begin
        if (send_resp) begin
          tx_shift_nxt = {1'b1, resp, 1'b0};
          tx_cnt_nxt   = FULL;
          tx_bit_nxt   = 4'd0;
          tx_state_nxt = TX_XMIT;
        end
      end
      TX_XMIT: begin
        if (tx_cnt == 12'd1) begin
          tx_shift_nxt = {1'b1, tx_shift[9:1]};
          tx_cnt_nxt   = FULL;
          if (tx_bit == 4'd9) begin
            tx_state_nxt  = TX_IDLE;
            tx_cnt_nxt    = '0;
            resp_sent_nxt = 1'b1;
          end else begin
            tx_bit_nxt = tx_bit + 4'd1;
          end
        end else begin
          tx_cnt_nxt = tx_cnt - 12'd1;
        end
      end
      default: tx_state_nxt = TX_IDLE;
    endcase
  end

  assign TX = tx_shift[0];

endmodule
